secure_key_store: RTL and testbench

Parametrised on-chip secret storage with per-slot write locks, a fixed preloaded key slot and a hardware zeroize sweep. It replaces the fixed six-entry secure RAM: requests arrive on a valid/ready port, and every accepted request returns a single-cycle response pulse with data and an error flag. It sits between the security controller and the crypto engines, which fetch keys from it. The zeroize input, driven by tamper/debug logic, wipes every slot.

---
 rtl/secure_key_store_if.sv | 28 ++
 rtl/secure_key_store.sv | 113 +++++++++++
 tb/tb_secure_key_store.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/secure_key_store_if.sv
// Request/response bus between the security controller and secure_key_store.
// Latency: the response comes one cycle after acceptance. Backpressure: req_ready stalls requests; the response side cannot stall.
// Ports: req_valid/req_ready/req_op/req_addr/req_wdata (request), rsp_valid/rsp_data/rsp_err (response).
interface secure_key_store_if #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/secure_key_store.sv
// Secret slot storage: per-slot write locks, one preloaded locked key slot and a zeroize sweep.
// Latency: a request accepted at edge N gives a one-cycle response in cycle N+1; the sweep takes DEPTH cycles.
// Backpressure: req_ready is low during a sweep, while zeroize is high and during reset. Responses cannot stall.
// Ports: clk, rst (sync, active high), zeroize (starts a wipe), busy (sweep running), bus (slave side of the request/response bus).
module secure_key_store #(
  parameter int               WIDTH    = 256,
  parameter int               DEPTH    = 8,
  parameter int               KEY_SLOT = 2,
  parameter logic [WIDTH-1:0] KEY_INIT =
    256'h49361d1ee0abd2c572b0edf565a9984c3ed4923ab2f88cd6b0eaa30d0c13ef1b
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                zeroize,
  output logic                busy,
  secure_key_store_if.slave   bus
);
  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One bit wider than the address so addresses above DEPTH-1 can be detected
  // when DEPTH is not a power of two.
  localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  typedef enum logic {IDLE, ZERO} state_t;

  state_t           state, state_next;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] lock;

  logic ready, accept, in_range;
  logic rd_en, wr_en, lock_en, err;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = !zeroize && !rst;
        if (zeroize) state_next = ZERO;
      end
      ZERO: begin
        if (cnt == LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready = ready;
  assign busy          = (state == ZERO);
  assign accept        = bus.req_valid && ready;
  assign in_range      = {1'b0, bus.req_addr} < DEPTH_W;

  // Op decode. Anything out of range or reserved is an error with no side effect.
  always_comb begin
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    lock_en = 1'b0;
    err     = 1'b1;
    if (in_range) begin
      case (bus.req_op)
        2'b00: begin
          rd_en = 1'b1;
          err   = 1'b0;
        end
        2'b01: begin
          wr_en = !lock[bus.req_addr];
          err   = lock[bus.req_addr];
        end
        2'b10: begin
          lock_en = 1'b1;
          err     = 1'b0;
        end
        default: err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i == KEY_SLOT) ? KEY_INIT : '0;
      end
      lock           <= '0;
      lock[KEY_SLOT] <= 1'b1;
      cnt            <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.rsp_data   <= '0;
    end else begin
      bus.rsp_valid <= accept;
      bus.rsp_err   <= accept && err;
      bus.rsp_data  <= (accept && rd_en) ? mem[bus.req_addr] : '0;

      // No request is accepted in ZERO, so the sweep never collides with a write.
      if (accept && wr_en)   mem[bus.req_addr]  <= bus.req_wdata;
      if (accept && lock_en) lock[bus.req_addr] <= 1'b1;

      if (state == ZERO) begin
        mem[cnt]  <= '0;
        lock[cnt] <= 1'b0;
        cnt       <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_secure_key_store.sv
// Directed bench for secure_key_store (DEPTH = 6) with a response scoreboard.
// Expected responses are queued when a request is driven and compared when rsp_valid pulses.
// Ports: none; instantiates the interface and the DUT.
module tb_secure_key_store;
  localparam int W = 256;
  localparam int D = 6;
  localparam logic [W-1:0] KEY =
    256'h49361d1ee0abd2c572b0edf565a9984c3ed4923ab2f88cd6b0eaa30d0c13ef1b;
  localparam logic [W-1:0] A5 = {32{8'hA5}};

  typedef struct {
    logic         err;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic zeroize = 1'b0;
  logic busy;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  secure_key_store_if #(.WIDTH(W), .DEPTH(D)) bus ();

  secure_key_store #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .zeroize (zeroize),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare every response pulse, and idle rsp_data must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rsp_valid === 1'b1) begin
        check("rsp_expected", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_err", W'(bus.rsp_err), W'(e.err));
          check("rsp_data", bus.rsp_data, e.data);
        end
      end else begin
        check("idle_rsp_data", bus.rsp_data, '0);
      end
    end
  end

  // Drive one request, starting just after a rising edge; it must be accepted.
  task automatic issue(input logic [1:0] op, input logic [2:0] addr, input logic [W-1:0] wd,
                       input logic eerr, input logic [W-1:0] edata);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    e.err  = eerr;
    e.data = edata;
    exp_q.push_back(e);
    #1;
    check("req_ready_for_issue", W'(bus.req_ready), W'(1));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", W'(exp_q.size() == 0), W'(1));
    exp_q.delete();
  endtask

  initial begin
    int busy_cycles;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset
    @(posedge clk);
    #1;
    check("ready_in_reset", W'(bus.req_ready), W'(0));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_busy", W'(busy), W'(0));
    check("reset_rsp_valid", W'(bus.rsp_valid), W'(0));
    check("reset_ready", W'(bus.req_ready), W'(1));
    @(posedge clk);
    #1;

    // Key slot and plain reads
    issue(2'b00, 3'd2, '0, 1'b0, KEY);
    issue(2'b00, 3'd0, '0, 1'b0, '0);

    // Write then read-after-write, locked key slot write
    issue(2'b01, 3'd5, A5, 1'b0, '0);
    issue(2'b00, 3'd5, '0, 1'b0, A5);
    issue(2'b01, 3'd2, A5, 1'b1, '0);
    issue(2'b00, 3'd2, '0, 1'b0, KEY);

    // Lock then write, relock
    issue(2'b10, 3'd5, '0, 1'b0, '0);
    issue(2'b01, 3'd5, W'(1), 1'b1, '0);
    issue(2'b00, 3'd5, '0, 1'b0, A5);
    issue(2'b10, 3'd5, '0, 1'b0, '0);

    // Out-of-range address and reserved op
    issue(2'b00, 3'd7, '0, 1'b1, '0);
    issue(2'b01, 3'd6, A5, 1'b1, '0);
    issue(2'b11, 3'd1, '0, 1'b1, '0);

    // Fill every slot; 2 and 5 are locked
    for (int i = 0; i < D; i++) begin
      issue(2'b01, 3'(i), {8{32'(i + 1)}}, (i == 2 || i == 5), '0);
    end
    issue(2'b00, 3'd3, '0, 1'b0, {8{32'd4}});
    drain();

    // Zeroize presented with a request: request must not be taken
    zeroize       = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_addr  = 3'd0;
    #1;
    check("ready_with_zeroize", W'(bus.req_ready), W'(0));
    @(posedge clk);
    #1;
    zeroize       = 1'b0;
    bus.req_valid = 1'b0;
    busy_cycles   = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      check("ready_during_sweep", W'(bus.req_ready), W'(0));
      busy_cycles++;
    end
    check("sweep_length", W'(busy_cycles), W'(D));
    check("ready_after_sweep", W'(bus.req_ready), W'(1));
    @(posedge clk);
    #1;

    // Everything wiped, key slot now writable
    for (int i = 0; i < D; i++) begin
      issue(2'b00, 3'(i), '0, 1'b0, '0);
    end
    issue(2'b01, 3'd2, A5, 1'b0, '0);
    issue(2'b00, 3'd2, '0, 1'b0, A5);
    for (int i = 0; i < D; i++) begin
      if (i != 2) issue(2'b01, 3'(i), {8{32'(i + 16)}}, 1'b0, '0);
    end
    drain();

    // Reset in the middle of a sweep (count 3)
    zeroize = 1'b1;
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_mid_sweep", W'(busy), W'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("busy_after_rst", W'(busy), W'(0));
    check("ready_after_rst", W'(bus.req_ready), W'(1));
    @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) begin
      issue(2'b00, 3'(i), '0, 1'b0, (i == 2) ? KEY : '0);
    end
    issue(2'b01, 3'd2, A5, 1'b1, '0);
    issue(2'b00, 3'd2, '0, 1'b0, KEY);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
